des_req_arbiter: RTL

DES_REQ_ARBITER -- requirements
Module: des_req_arbiter

---
 rtl/des_req_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/des_req_arbiter.sv
// Two-requester front end for a shared, fixed-latency DES core: grants one request, issues it, waits out the core latency and holds the result until consumed.
// Build option: define DES_ARB_RR_EN for round-robin between simultaneous requests (default is fixed priority to requester 0).
module des_req_arbiter #(
    parameter int CORE_LATENCY = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [63:0] req0_key,
    input  logic [63:0] req1_key,
    input  logic [63:0] req0_data,
    input  logic [63:0] req1_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_id,
    output logic        core_load,
    output logic [63:0] core_key_in,
    output logic [63:0] core_data_in,
    input  logic [63:0] core_data_out,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_key;
    logic [63:0]   r_data;
    logic [63:0]   r_out_data;
    logic          r_out_id;

    logic w_idle;
    logic w_pick1;
    logic w_accept;

`ifdef DES_ARB_RR_EN
    logic r_ptr;

    // r_ptr names the requester favoured on a tie: the one not served last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (r_state == S_RESP && out_ready) begin
            r_ptr <= ~r_out_id;
        end
    end

    assign w_pick1 = req1_valid && (!req0_valid || r_ptr);
`else
    assign w_pick1 = req1_valid && !req0_valid;
`endif

    assign w_idle     = (r_state == S_IDLE) && !reset;
    assign req0_ready = w_idle && req0_valid && !w_pick1;
    assign req1_ready = w_idle && w_pick1;
    assign w_accept   = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_key      <= '0;
            r_data     <= '0;
            r_out_data <= '0;
            r_out_id   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_key    <= req1_ready ? req1_key  : req0_key;
                        r_data   <= req1_ready ? req1_data : req0_data;
                        r_out_id <= req1_ready;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CW'(CORE_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter reaching zero lines up with the core's result edge.
                    if (r_cnt == '0) begin
                        r_out_data <= core_data_out;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_load    = (r_state == S_ISSUE);
    assign out_valid    = (r_state == S_RESP);
    assign busy         = (r_state != S_IDLE);
    assign core_key_in  = r_key;
    assign core_data_in = r_data;
    assign out_data     = r_out_data;
    assign out_id       = r_out_id;

endmodule
